// File: rtl/mem_refill_pkg.sv
// mem_refill_pkg: state encoding, default parameters and sizing helpers
// shared by the line-refill responder and its storage array.
package mem_refill_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Default configuration.
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_LINE_WORDS  = 4;
    localparam int DEF_MEM_LATENCY = 3;
    localparam int DEF_MEM_DEPTH   = 1024;

    // Width of one counter shared by the WAIT and BURST phases.
    function automatic int cnt_width(input int lat, input int words);
        int top;
        top = (lat > words) ? lat : words;
        return (top < 2) ? 1 : $clog2(top + 1);
    endfunction

    // Low byte-address bits that select a byte inside one word.
    function automatic int byte_off_width(input int data_w);
        return (data_w > 8) ? $clog2(data_w / 8) : 0;
    endfunction

endpackage

// File: rtl/mem_refill_responder_array.sv
// mem_word_array: word-wide backing store with one synchronous
// write port and one combinational read port; contents are not reset.
module mem_word_array
    import mem_refill_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_MEM_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Preload write; a read of the same index this cycle sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_refill_responder.sv
// mem_refill_responder: answers cache line-refill requests from a local
// word store after a fixed latency. Optional macro MEM_REFILL_ERR_EN adds mem_err.
module mem_refill_responder
    import mem_refill_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int MEM_LATENCY = DEF_MEM_LATENCY,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_req,
    input  logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_ready,
    output logic [DATA_W*LINE_WORDS-1:0] mem_line,
    output logic                         busy,
`ifdef MEM_REFILL_ERR_EN
    output logic                         mem_err,
`endif
    input  logic                         load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [DATA_W-1:0]            load_data
);

    localparam int AW       = $clog2(MEM_DEPTH);
    localparam int LINE_W   = DATA_W * LINE_WORDS;
    localparam int OFF_W    = byte_off_width(DATA_W);
    localparam int CNT_W    = cnt_width(MEM_LATENCY, LINE_WORDS);
    localparam int LAT_LAST = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;
    localparam int WRD_LAST = LINE_WORDS - 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LINE_W-1:0]   buf_q, buf_d;
    logic [LINE_W-1:0]   line_q, line_d;

    logic [ADDR_W-1:0]   req_word;
    logic [AW-1:0]       rd_idx;
    logic [DATA_W-1:0]   rd_data;
    logic [DATA_W-1:0]   rd_word;
    logic [LINE_W-1:0]   shifted;

`ifdef MEM_REFILL_ERR_EN
    logic                err_q, err_d;
    logic                req_err;
`endif

    // Word index of the first word of the requested line.
    assign req_word = (mem_addr >> OFF_W)
                    & ~(ADDR_W'(LINE_WORDS - 1));

    // Offsets within a line never carry, so adding then wrapping is exact.
    assign rd_idx = AW'(base_q + ADDR_W'(cnt_q));

`ifdef MEM_REFILL_ERR_EN
    assign req_err = (req_word >> AW) != '0;
    assign rd_word = err_q ? '0 : rd_data;
`else
    assign rd_word = rd_data;
`endif

    // New word enters at the top; after a full burst word 0 sits in the LSBs.
    assign shifted = LINE_W'({rd_word, buf_q} >> DATA_W);

    mem_word_array #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_idx),
        .rdata (rd_data)
    );

    // Next-state, counter and line assembly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        buf_d   = buf_q;
        line_d  = line_q;
`ifdef MEM_REFILL_ERR_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    base_d  = req_word;
                    cnt_d   = '0;
`ifdef MEM_REFILL_ERR_EN
                    err_d   = req_err;
`endif
                    state_d = (MEM_LATENCY > 0) ? ST_WAIT : ST_BURST;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(LAT_LAST)) begin
                    cnt_d   = '0;
                    state_d = ST_BURST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BURST: begin
                buf_d = shifted;
                if (cnt_q == CNT_W'(WRD_LAST)) begin
                    line_d  = shifted;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            buf_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            buf_q   <= buf_d;
            line_q  <= line_d;
        end
    end

`ifdef MEM_REFILL_ERR_EN
    // Out-of-range flag for the line being served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign mem_err = (state_q == ST_RESP) & err_q;
`endif

    assign mem_ready = (state_q == ST_RESP);
    assign busy      = (state_q != ST_IDLE);
    assign mem_line  = line_q;

endmodule

// File: tb/tb_mem_refill_responder.sv
// tb_mem_refill_responder: directed stimulus with a time-offset model of
// the refill protocol plus literal line/latency expectations.
module tb_mem_refill_responder;

    localparam int L  = 3;
    localparam int LW = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_req, mem_req0;
    logic [31:0]  mem_addr, mem_addr0;
    logic         mem_ready, mem_ready0;
    logic         busy, busy0;
    logic [127:0] mem_line, mem_line0;
    logic         load_en;
    logic [9:0]   load_addr;
    logic [31:0]  load_data;
`ifdef MEM_REFILL_ERR_EN
    logic         mem_err, mem_err0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_refill_responder #(.MEM_LATENCY(L)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_line  (mem_line),
        .busy      (busy),
`ifdef MEM_REFILL_ERR_EN
        .mem_err   (mem_err),
`endif
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    mem_refill_responder #(.MEM_LATENCY(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req0),
        .mem_addr  (mem_addr0),
        .mem_ready (mem_ready0),
        .mem_line  (mem_line0),
        .busy      (busy0),
`ifdef MEM_REFILL_ERR_EN
        .mem_err   (mem_err0),
`endif
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int w);
        return (w < 4) ? 32'hA0 + 32'(w) : 32'hC000_0000 + 32'(w);
    endfunction

    // Model: k = edges since acceptance; word i is captured at k = L+1+i,
    // the line is published at k = L+LW and ready is high for the cycle after.
    bit           m_act  = 1'b0;
    int           m_k    = 0;
    int unsigned  m_base = 0;
    bit           m_err  = 1'b0;
    logic [127:0] m_buf  = '0;
    logic [127:0] m_line = '0;
    logic [31:0]  mm [1024];

    always @(posedge clk or posedge rst) begin
        int i;
        if (rst) begin
            m_act  = 1'b0;
            m_k    = 0;
            m_line = '0;
            m_err  = 1'b0;
        end else begin
            if (m_act) begin
                m_k++;
                if (m_k >= L + 1 && m_k <= L + LW) begin
                    i = m_k - L - 1;
                    m_buf[i*32 +: 32] = m_err ? 32'h0
                                      : mm[(m_base + i) % 1024];
                end
                if (m_k == L + LW) m_line = m_buf;
                if (m_k == L + LW + 1) m_act = 1'b0;
            end else if (mem_req) begin
                m_act  = 1'b1;
                m_k    = 0;
                m_base = (mem_addr >> 4) << 2;
`ifdef MEM_REFILL_ERR_EN
                m_err  = (m_base >= 1024);
`else
                m_err  = 1'b0;
`endif
            end
            if (load_en) mm[load_addr] = load_data;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy", busy, m_act);
        chk("ready", mem_ready, m_act && m_k == L + LW);
        chk("line", mem_line, m_line);
`ifdef MEM_REFILL_ERR_EN
        chk("err", mem_err, m_act && m_k == L + LW && m_err);
`endif
    end

    // One-cycle request; returns the edge (counted from the sampling
    // edge) at which mem_ready is first seen high.
    task automatic do_req(input bit sel, input logic [31:0] a,
                          output int e);
        int n;
        if (sel) begin mem_req0 = 1'b1; mem_addr0 = a; end
        else     begin mem_req  = 1'b1; mem_addr  = a; end
        @(posedge clk);
        @(negedge clk);
        mem_req  = 1'b0;
        mem_req0 = 1'b0;
        n = 0;
        while (!(sel ? mem_ready0 : mem_ready) && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        e = n + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int e, n, lo, hi, rp;
        rst = 1'b1; mem_req = 1'b0; mem_req0 = 1'b0;
        mem_addr = '0; mem_addr0 = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", mem_ready, 0);
        chk("rst_line", mem_line, 0);
        chk("rst_busy0", busy0, 0);
        chk("rst_line0", mem_line0, 0);
        rst = 1'b0;

        for (int w = 0; w < 1024; w++) begin
            load_en = 1'b1; load_addr = 10'(w); load_data = pat(w);
            @(negedge clk);
        end
        load_en = 1'b0;

        // Basic refill of line 0.
        do_req(0, 32'h0, e);
        chk("lat_l3", e, 8);
        chk("line0", mem_line,
            128'h000000A3_000000A2_000000A1_000000A0);
        chk("model_line0", m_line,
            128'h000000A3_000000A2_000000A1_000000A0);
        @(negedge clk);

        // Alignment, with and without latency.
        do_req(0, 32'h1C, e);
        chk("line_1c", mem_line,
            128'hC0000007_C0000006_C0000005_C0000004);
        @(negedge clk);
        do_req(1, 32'h1C, e);
        chk("lat_l0", e, 5);
        chk("line0_1c", mem_line0,
            128'hC0000007_C0000006_C0000005_C0000004);
        chk("l0_ready_len", mem_ready0, 1);
        @(negedge clk);
        chk("l0_idle", busy0, 0);

        // Back-to-back with mem_req held.
        mem_addr = 32'h20; mem_req = 1'b1;
        n = 0;
        while (!mem_ready && n < 40) begin @(negedge clk); n++; end
        chk("b2b_first", mem_ready, 1);
        @(negedge clk);
        lo = 0;
        while (!busy && lo < 20) begin lo++; @(negedge clk); end
        hi = 0; rp = 0;
        while (busy && hi < 20) begin
            hi++;
            if (mem_ready) rp++;
            @(negedge clk);
        end
        mem_req = 1'b0;
        chk("b2b_gap", lo, 1);
        chk("b2b_busy", hi, 8);
        chk("b2b_pulses", rp, 1);
        chk("b2b_line", mem_line,
            128'hC000000B_C000000A_C0000009_C0000008);
        @(negedge clk);

        // Reset in the middle of a burst.
        mem_addr = 32'h40; mem_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_req = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstb_busy", busy, 0);
        chk("rstb_ready", mem_ready, 0);
        chk("rstb_line", mem_line, 0);
        @(negedge clk);
        rst = 1'b0;
        rp = 0;
        repeat (12) begin
            @(negedge clk);
            if (mem_ready) rp++;
        end
        chk("rstb_nopulse", rp, 0);
        do_req(0, 32'h40, e);
        chk("rstb_lat", e, 8);
        chk("rstb_line2", mem_line,
            128'hC0000013_C0000012_C0000011_C0000010);
        @(negedge clk);

        // Top of storage and one past it.
        do_req(0, 32'hFFC, e);
        chk("line_top", mem_line,
            128'hC00003FF_C00003FE_C00003FD_C00003FC);
        @(negedge clk);
        do_req(0, 32'h1000, e);
`ifdef MEM_REFILL_ERR_EN
        chk("err_flag", mem_err, 1);
        chk("err_line", mem_line, 0);
`else
        chk("wrap_line", mem_line,
            128'h000000A3_000000A2_000000A1_000000A0);
`endif
        @(negedge clk);

        // Write word 2 during the cycle it is being read.
        mem_addr = 32'h8; mem_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_req = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        load_en = 1'b1; load_addr = 10'd2; load_data = 32'h0000BEEF;
        @(negedge clk);
        load_en = 1'b0;
        n = 0;
        while (!mem_ready && n < 20) begin @(negedge clk); n++; end
        chk("wr_old", mem_line,
            128'h000000A3_000000A2_000000A1_000000A0);
        @(negedge clk);
        do_req(0, 32'h8, e);
        chk("wr_new", mem_line,
            128'h000000A3_0000BEEF_000000A1_000000A0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
